// File: rtl/dot_prod_sched.sv
// Lag-sweep sequencer: issues x/y sample reads for every (lag, k) pair,
// forwards tvalid into the dot-product pipeline and counts returned products.
module dot_prod_sched #(
  parameter int LENGTH     = 8,
  parameter int LAGS       = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int LAG_WIDTH  = 2,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] y_offset,
  input  logic                  sink_ready,
  input  logic                  s_axis_product_tvalid,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  m_axis_x_tvalid,
  output logic                  m_axis_y_tvalid,
  output logic                  pair_last,
  output logic [LAG_WIDTH-1:0]  lag_index,
  output logic                  lag_done,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start; products are ignored
  // ISSUE | issuing one (k, lag) pair per sink_ready cycle
  // DRAIN | all pairs issued, waiting for the remaining products
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int KW = $clog2(LENGTH);
  localparam logic [KW-1:0]        K_LAST    = KW'(LENGTH - 1);
  localparam logic [LAG_WIDTH-1:0] LAG_LAST  = LAG_WIDTH'(LAGS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_TOTAL = CNT_WIDTH'(LENGTH * LAGS);

  state_t                 state;
  logic [KW-1:0]          k;
  logic [LAG_WIDTH-1:0]   lag;
  logic [ADDR_WIDTH-1:0]  y_base;
  logic                   issue_last;
  logic [LAG_WIDTH-1:0]   issue_lag;
  logic [CNT_WIDTH-1:0]   res_cnt;
  logic [KW-1:0]          prod_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      k               <= '0;
      lag             <= '0;
      y_base          <= '0;
      issue_last      <= 1'b0;
      issue_lag       <= '0;
      res_cnt         <= '0;
      prod_left       <= '0;
      rd_en           <= 1'b0;
      x_addr          <= '0;
      y_addr          <= '0;
      m_axis_x_tvalid <= 1'b0;
      m_axis_y_tvalid <= 1'b0;
      pair_last       <= 1'b0;
      lag_index       <= '0;
      lag_done        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      rd_en           <= 1'b0;
      lag_done        <= 1'b0;
      done            <= 1'b0;
      // tvalid stage mirrors the previous cycle's issue
      m_axis_x_tvalid <= rd_en;
      m_axis_y_tvalid <= rd_en;
      pair_last       <= rd_en & issue_last;
      if (rd_en) lag_index <= issue_lag;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            y_base    <= y_offset;
            k         <= '0;
            lag       <= '0;
            res_cnt   <= '0;
            prod_left <= K_LAST;
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE && sink_ready) begin
            rd_en      <= 1'b1;
            x_addr     <= ADDR_WIDTH'(k);
            y_addr     <= y_base + ADDR_WIDTH'(k) + ADDR_WIDTH'(lag);
            issue_last <= (k == K_LAST);
            issue_lag  <= lag;
            if (k == K_LAST) begin
              k <= '0;
              if (lag == LAG_LAST) state <= DRAIN;
              else                 lag   <= lag + 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
          if (s_axis_product_tvalid) begin
            res_cnt <= res_cnt + 1'b1;
            // down-counter per lag; terminal count marks a completed lag
            if (prod_left == '0) begin
              lag_done  <= 1'b1;
              prod_left <= K_LAST;
            end else begin
              prod_left <= prod_left - 1'b1;
            end
            if (res_cnt == CNT_TOTAL - 1'b1) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
